// File: rtl/shift_add_mult_pkg.sv
// Shared types and sizing helpers for the
// shift-and-add multiplier.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 16;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_ripple_adder.sv
// Full-adder cell and the N-bit ripple-carry
// adder chained from it.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b)
              | (i_ci & (i_a ^ i_b));

endmodule

module ripple_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] w_c;

  assign w_c[0] = cin;
  assign cout   = w_c[N];

  for (genvar i = 0; i < N; i++) begin : g_fa
    fulladder u_fa (
      .i_a  (x[i]),
      .i_b  (y[i]),
      .i_ci (w_c[i]),
      .o_s  (s[i]),
      .o_co (w_c[i+1])
    );
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// SHIFT_ADD_MULT_EARLY_TERM_EN: stop once mplier is exhausted.
module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  state_e          r_state;
  state_e          w_nstate;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_sum;
  logic            w_cout;
  logic            w_last;
  logic            w_accept;
  logic            w_handoff;

  assign w_addend = r_mplier[0]
                  ? r_mcand : '0;

  ripple_adder #(.N(PW)) u_add (
    .x    (r_acc),
    .y    (w_addend),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  assign w_last = (r_cnt == LAST)
               || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_cnt == LAST);
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign product   = out_valid ? r_acc : '0;

  assign w_accept  = in_valid & in_ready;
  assign w_handoff = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (1'b1)
      (r_state == IDLE):
        if (w_accept) w_nstate = RUN;
      (r_state == RUN):
        if (w_last) w_nstate = DONE;
      (r_state == DONE):
        if (w_handoff) w_nstate = IDLE;
      default:
        w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= PW'(a);
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Partial sums never exceed a*b, so no carry.
  always_ff @(posedge clk) begin
    if (!rst && r_state == RUN)
      assert (!w_cout);
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for
// shift_add_multiplier (WIDTH=16).
module tb_shift_add_multiplier;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(
    input logic [W-1:0] bv
  );
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    int l;
    l = 1;
    for (int i = 0; i < W; i++)
      if (bv[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  int last_acc;

  // Accept, wait for out_valid, check latency and
  // product; optionally complete the handoff.
  task automatic run_op(
    input string          tag,
    input logic [W-1:0]   av,
    input logic [W-1:0]   bv,
    input logic [2*W-1:0] exp,
    input bit             handoff
  );
    int k;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    step();
    last_acc = cyc;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat(bv)));
    chk({tag, "_prod"}, 64'(product), 64'(exp));
    if (handoff) begin
      step();
      chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, "_ovld"}, 64'(out_valid), 64'd0);
    end
  endtask

  typedef struct {
    logic [W-1:0]   av;
    logic [W-1:0]   bv;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[20] = '{
    '{16'h0000, 16'h0000, 32'h00000000},
    '{16'h0000, 16'hFFFF, 32'h00000000},
    '{16'hFFFF, 16'h0000, 32'h00000000},
    '{16'h0001, 16'h0001, 32'h00000001},
    '{16'hFFFF, 16'h0001, 32'h0000FFFF},
    '{16'h0001, 16'hFFFF, 32'h0000FFFF},
    '{16'h0002, 16'h0003, 32'h00000006},
    '{16'h0010, 16'h0010, 32'h00000100},
    '{16'h0100, 16'h0100, 32'h00010000},
    '{16'h00FF, 16'h00FF, 32'h0000FE01},
    '{16'hFFFF, 16'h0002, 32'h0001FFFE},
    '{16'h8000, 16'h8000, 32'h40000000},
    '{16'hFFFF, 16'hFFFF, 32'hFFFE0001},
    '{16'h1234, 16'h0001, 32'h00001234},
    '{16'h0003, 16'h0005, 32'h0000000F},
    '{16'h0007, 16'h0009, 32'h0000003F},
    '{16'hAAAA, 16'h0002, 32'h00015554},
    '{16'h5555, 16'h0003, 32'h0000FFFF},
    '{16'h0F0F, 16'h0101, 32'h000F1E0F},
    '{16'h4000, 16'h0004, 32'h00010000}
  };

  initial begin
    logic [2*W-1:0] held;
    int prev_acc;
    int prev_lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_rdy",  64'(in_ready),  64'd1);
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    chk("rst_prod", 64'(product),   64'd0);

    run_op("m3x5", 16'd3, 16'd5, 32'hF, 1'b1);
    run_op("mffff", 16'hFFFF, 16'hFFFF,
           32'hFFFE0001, 1'b1);
    run_op("m8000", 16'h8000, 16'h0002,
           32'h00010000, 1'b1);

    // Backpressure with a stray request.
    out_ready = 1'b0;
    run_op("bp", 16'h0123, 16'h0100,
           32'h00012300, 1'b0);
    held = product;
    for (int i = 0; i < 10; i++) begin
      a        = 16'h00FF;
      b        = 16'h00FF;
      in_valid = 1'b1;
      step();
      chk("bp_ovld", 64'(out_valid), 64'd1);
      chk("bp_prod", 64'(product), 64'(held));
      chk("bp_rdy",  64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_rel_ovld", 64'(out_valid), 64'd0);
    chk("bp_rel_rdy",  64'(in_ready),  64'd1);
    step();
    chk("bp_no_acc", 64'(busy), 64'd0);

    // Reset in the middle of an operation.
    a        = 16'h1234;
    b        = 16'h5678;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_rdy",  64'(in_ready),  64'd1);
    chk("mr_ovld", 64'(out_valid), 64'd0);
    chk("mr_prod", 64'(product),   64'd0);
    chk("mr_busy", 64'(busy),      64'd0);
    run_op("m1234", 16'h1234, 16'h5678,
           32'h06260060, 1'b1);

    // Back-to-back stream.
    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("b2b%0d", i),
             vecs[i].av, vecs[i].bv,
             vecs[i].p, 1'b1);
      if (i > 0)
        chk($sformatf("b2b%0d_gap", i),
            64'(last_acc - prev_acc),
            64'(prev_lat + 2));
      prev_acc = last_acc;
      prev_lat = exp_lat(vecs[i].bv);
    end

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    run_op("et7x5", 16'd7, 16'd5,
           32'h23, 1'b1);
    run_op("et9x0", 16'd9, 16'd0,
           32'h0, 1'b1);
    run_op("et_msb", 16'd3, 16'h8000,
           32'h00018000, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
